// File: rtl/router_reg.sv
// Datapath register block of the 1x3 packet router: header latch, byte forwarding,
// FIFO-full byte parking and running XOR parity check. Optional macro: ROUTER_REG_ERR_STICKY_EN.
module router_reg (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       detect_add,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       lfd_state,
    input  logic       rst_int_reg,
    output logic       err,
    output logic       parity_done,
    output logic       low_packet_valid,
    output logic [7:0] dout
);

    logic [7:0] header_byte;
    logic [7:0] full_byte;
    logic [7:0] int_parity;
    logic [7:0] pkt_parity;

    // A header carrying the invalid address 2'b11 never replaces the stored one.
    always_ff @(posedge clock) begin
        if (resetn)
            header_byte <= '0;
        else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
            header_byte <= data_in;
    end

    always_ff @(posedge clock) begin
        if (resetn)
            dout <= '0;
        else if (lfd_state)
            dout <= header_byte;
        else if (ld_state && !fifo_full)
            dout <= data_in;
        else if (laf_state)
            dout <= full_byte;
    end

    // Byte parked while the FIFO is full, replayed in LOAD_AFTER_FULL.
    always_ff @(posedge clock) begin
        if (resetn)
            full_byte <= '0;
        else if (ld_state && fifo_full)
            full_byte <= data_in;
    end

    always_ff @(posedge clock) begin
        if (resetn)
            int_parity <= '0;
        else if (detect_add)
            int_parity <= '0;
        else if (lfd_state)
            int_parity <= int_parity ^ header_byte;
        else if (ld_state && pkt_valid && !full_state)
            int_parity <= int_parity ^ data_in;
    end

    always_ff @(posedge clock) begin
        if (resetn)
            pkt_parity <= '0;
        else if (detect_add)
            pkt_parity <= '0;
        else if (ld_state && !pkt_valid)
            pkt_parity <= data_in;
    end

    always_ff @(posedge clock) begin
        if (resetn)
            parity_done <= 1'b0;
        else if (detect_add)
            parity_done <= 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_packet_valid && !parity_done))
            parity_done <= 1'b1;
    end

    // Clear request wins over a same-cycle set.
    always_ff @(posedge clock) begin
        if (resetn)
            low_packet_valid <= 1'b0;
        else if (rst_int_reg)
            low_packet_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_packet_valid <= 1'b1;
    end

`ifdef ROUTER_REG_ERR_STICKY_EN
    always_ff @(posedge clock) begin
        if (resetn)
            err <= 1'b0;
        else if (err)
            err <= 1'b1;
        else if (detect_add)
            err <= 1'b0;
        else if (parity_done)
            err <= (int_parity != pkt_parity);
    end
`else
    always_ff @(posedge clock) begin
        if (resetn)
            err <= 1'b0;
        else if (detect_add)
            err <= 1'b0;
        else if (parity_done)
            err <= (int_parity != pkt_parity);
    end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg: reset, good/bad packets, FIFO-full
// parking, low_packet_valid clear and invalid-address header handling.
module tb_router_reg;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic       err;
    logic       parity_done;
    logic       low_packet_valid;
    logic [7:0] dout;

    int total_checks = 0;
    int bad_checks   = 0;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_DET  = 5'b10000;
    localparam logic [4:0] S_LFD  = 5'b01000;
    localparam logic [4:0] S_LD   = 5'b00100;
    localparam logic [4:0] S_LAF  = 5'b00010;
    localparam logic [4:0] S_FULL = 5'b00001;

`ifdef ROUTER_REG_ERR_STICKY_EN
    localparam logic ERR_AFTER_DETECT = 1'b1;
`else
    localparam logic ERR_AFTER_DETECT = 1'b0;
`endif

    logic [7:0] payload [8] = '{8'h3C, 8'h81, 8'h5A, 8'h07, 8'hF0, 8'h99, 8'h26, 8'hD4};
    logic [7:0] parity;

    router_reg dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .lfd_state        (lfd_state),
        .rst_int_reg      (rst_int_reg),
        .err              (err),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .dout             (dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, then let outputs settle 1 time unit past the edge.
    task automatic applyStimulus(input logic [4:0] strobes, input logic pv, input logic [7:0] d,
                                 input logic ff, input logic ri, input logic rst);
        resetn      = rst;
        detect_add  = strobes[4];
        lfd_state   = strobes[3];
        ld_state    = strobes[2];
        laf_state   = strobes[1];
        full_state  = strobes[0];
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        rst_int_reg = ri;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic sendPacket(input logic [7:0] trailer, input logic check_dout);
        applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        if (check_dout) checkOutput("lfd_dout_header", dout, 8'h22);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(S_LD, 1'b1, payload[i], 1'b0, 1'b0, 1'b0);
            if (check_dout) checkOutput($sformatf("payload_dout_%0d", i), dout, payload[i]);
        end
        applyStimulus(S_LD, 1'b0, trailer, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        parity = 8'h22;
        for (int i = 0; i < 8; i++) parity = parity ^ payload[i];

        // Reset
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_dout", dout, 8'h00);
        checkOutput("reset_err", {7'd0, err}, 8'h00);
        checkOutput("reset_parity_done", {7'd0, parity_done}, 8'h00);
        checkOutput("reset_lpv", {7'd0, low_packet_valid}, 8'h00);

        // Good packet
        sendPacket(parity, 1'b1);
        checkOutput("good_parity_done", {7'd0, parity_done}, 8'h01);
        checkOutput("good_lpv", {7'd0, low_packet_valid}, 8'h01);
        checkOutput("good_dout_parity", dout, parity);
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("good_err", {7'd0, err}, 8'h00);

        // Clear low_packet_valid
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_int_clear", {7'd0, low_packet_valid}, 8'h00);

        // Bad packet
        sendPacket(~parity, 1'b0);
        checkOutput("bad_parity_done", {7'd0, parity_done}, 8'h01);
        checkOutput("bad_err_latency", {7'd0, err}, 8'h00);
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("bad_err", {7'd0, err}, 8'h01);
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("bad_err_hold", {7'd0, err}, 8'h01);
        applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        checkOutput("detect_err", {7'd0, err}, {7'd0, ERR_AFTER_DETECT});
        checkOutput("detect_parity_done", {7'd0, parity_done}, 8'h00);

        // Same-cycle set and clear of low_packet_valid
        applyStimulus(S_LD, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("lpv_set_clear", {7'd0, low_packet_valid}, 8'h00);

        // FIFO full: park 0xA5, replay on LOAD_AFTER_FULL
        applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_LD, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        checkOutput("full_pre_dout", dout, 8'h11);
        applyStimulus(S_LD, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("full_hold_dout", dout, 8'h11);
        applyStimulus(S_FULL, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("full_state_dout", dout, 8'h11);
        applyStimulus(S_LAF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("laf_dout", dout, 8'hA5);

        // Parity byte arriving while full completes through LOAD_AFTER_FULL
        applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        checkOutput("det_lpv_clear", {7'd0, low_packet_valid}, 8'h00);
        applyStimulus(S_LD, 1'b0, 8'h5E, 1'b1, 1'b0, 1'b0);
        checkOutput("full_par_lpv", {7'd0, low_packet_valid}, 8'h01);
        checkOutput("full_par_pd", {7'd0, parity_done}, 8'h00);
        applyStimulus(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("laf_pd", {7'd0, parity_done}, 8'h01);
        checkOutput("laf_par_dout", dout, 8'h5E);

        // Invalid-address header keeps the previous header
        applyStimulus(S_DET, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_DET, 1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("invalid_addr_dout", dout, 8'h22);

        // Reset mid-packet
        applyStimulus(S_LD, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_dout", dout, 8'h00);
        checkOutput("midrst_pd", {7'd0, parity_done}, 8'h00);
        checkOutput("midrst_lpv", {7'd0, low_packet_valid}, 8'h00);
        checkOutput("midrst_err", {7'd0, err}, 8'h00);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
